// File: rtl/bp_cce_inst_fetch_mc.sv
// Multi-context microcode fetch: round-robin over enabled contexts, one shared single-port RAM.
// Config access always wins the RAM port; a stalled instruction is refetched until yumi_i.
module bp_cce_inst_fetch_mc #(
    parameter int instr_width_p = 48,
    parameter int els_p         = 256,
    parameter int ctx_p         = 4,
    localparam int pc_width_lp  = $clog2(els_p),
    localparam int ctx_width_lp = (ctx_p > 1) ? $clog2(ctx_p) : 1
) (
    input  logic                           clk_i,
    input  logic                           reset_n_i,
    input  logic                           normal_mode_i,
    input  logic                           cfg_w_v_i,
    input  logic                           cfg_r_v_i,
    input  logic [pc_width_lp-1:0]         cfg_addr_i,
    input  logic [instr_width_p-1:0]       cfg_data_i,
    output logic                           cfg_r_v_o,
    output logic [instr_width_p-1:0]       cfg_r_data_o,
    input  logic [ctx_p*pc_width_lp-1:0]   boot_pc_i,
    input  logic [ctx_p-1:0]               ctx_en_i,
    output logic                           inst_v_o,
    output logic [instr_width_p-1:0]       inst_o,
    output logic [ctx_width_lp-1:0]        inst_ctx_o,
    output logic [pc_width_lp-1:0]         inst_pc_o,
    input  logic                           yumi_i,
    input  logic [pc_width_lp-1:0]         predicted_pc_i,
    input  logic [pc_width_lp-1:0]         resolution_pc_i,
    input  logic                           mispredict_i
);

    typedef enum logic [1:0] {S_RESET, S_INIT, S_INIT_END, S_FETCH} state_e;

    state_e                    state_q, state_d;
    logic                      inst_v_q, cfg_r_v_q, pend_q, pend_d;
    logic [ctx_width_lp-1:0]   inst_ctx_q, ptr_q, ptr_d, pick, ptr_nxt, fetch_ctx;
    logic [pc_width_lp-1:0]    inst_pc_q, fetch_pc, new_pc, ram_addr;
    logic [pc_width_lp-1:0]    ctx_pc_q [ctx_p];
    logic [instr_width_p-1:0]  mem [els_p];
    logic [instr_width_p-1:0]  data_q;
    logic                      cfg_acc, acc, held, found, fetch_v, ram_rd;
    int                        idx;

    assign cfg_acc = cfg_w_v_i | cfg_r_v_i;
    assign acc     = inst_v_q & yumi_i;
    assign new_pc  = mispredict_i ? resolution_pc_i : predicted_pc_i;
    // pend_q marks inst_ctx_q/inst_pc_q as issued but not yet accepted
    assign held    = pend_q & ~acc;
    assign ptr_nxt = (pick == ctx_width_lp'(ctx_p - 1)) ? '0 : pick + ctx_width_lp'(1);

    // ptr_q is where the search starts, i.e. one past the last-served context
    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx   = 0;
        for (int k = ctx_p - 1; k >= 0; k--) begin
            idx = (int'(ptr_q) + k) % ctx_p;
            if (ctx_en_i[ctx_width_lp'(idx)]) begin
                found = 1'b1;
                pick  = ctx_width_lp'(idx);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        fetch_v   = 1'b0;
        fetch_ctx = inst_ctx_q;
        fetch_pc  = inst_pc_q;
        ptr_d     = ptr_q;
        case (state_q)
            S_RESET:    state_d = S_INIT;
            S_INIT:     if (normal_mode_i) state_d = S_INIT_END;
            S_INIT_END: begin
                state_d = S_FETCH;
                ptr_d   = '0;
            end
            S_FETCH: begin
                if (!normal_mode_i) begin
                    state_d = S_INIT;
                end else if (!cfg_acc) begin
                    if (held) begin
                        fetch_v = 1'b1;
                    end else if (found) begin
                        fetch_v   = 1'b1;
                        fetch_ctx = pick;
                        fetch_pc  = (acc && pick == inst_ctx_q) ? new_pc : ctx_pc_q[pick];
                        ptr_d     = ptr_nxt;
                    end
                end
            end
            default:    state_d = S_RESET;
        endcase
    end

    assign pend_d   = (state_q != S_FETCH) ? 1'b0 : (fetch_v | (pend_q & ~acc));
    assign ram_addr = cfg_acc ? cfg_addr_i : fetch_pc;
    assign ram_rd   = (cfg_r_v_i & ~cfg_w_v_i) | fetch_v;

    always_ff @(posedge clk_i) begin
        if (cfg_w_v_i) mem[ram_addr] <= cfg_data_i;
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q    <= S_RESET;
            inst_v_q   <= 1'b0;
            cfg_r_v_q  <= 1'b0;
            pend_q     <= 1'b0;
            ptr_q      <= '0;
            inst_ctx_q <= '0;
            inst_pc_q  <= '0;
            data_q     <= '0;
            for (int k = 0; k < ctx_p; k++) ctx_pc_q[k] <= '0;
        end else begin
            state_q   <= state_d;
            inst_v_q  <= fetch_v;
            cfg_r_v_q <= cfg_r_v_i & ~cfg_w_v_i;
            pend_q    <= pend_d;
            ptr_q     <= ptr_d;
            if (ram_rd) data_q <= mem[ram_addr];
            if (fetch_v) begin
                inst_ctx_q <= fetch_ctx;
                inst_pc_q  <= fetch_pc;
            end
            if (state_q == S_INIT_END) begin
                for (int k = 0; k < ctx_p; k++)
                    ctx_pc_q[k] <= boot_pc_i[k*pc_width_lp +: pc_width_lp];
            end else if (acc) begin
                ctx_pc_q[inst_ctx_q] <= new_pc;
            end
        end
    end

    assign inst_v_o     = inst_v_q;
    assign inst_o       = data_q;
    assign inst_ctx_o   = inst_ctx_q;
    assign inst_pc_o    = inst_pc_q;
    assign cfg_r_v_o    = cfg_r_v_q;
    assign cfg_r_data_o = data_q;

endmodule

// File: doc/bp_cce_inst_fetch_mc.md
BP_CCE_INST_FETCH_MC -- requirements
Module: bp_cce_inst_fetch_mc

Interface
REQ-001 SHALL have parameter instr_width_p, default 48: microcode instruction width in bits.
REQ-002 SHALL have parameter els_p, default 256: instruction RAM depth; pc_width = clog2(els_p).
REQ-003 SHALL have parameter ctx_p, default 4: number of fetch contexts (1..16); ctx_width = max(1, clog2(ctx_p)).
REQ-004 SHALL have clk_i  in  1  clock; all state updates on the rising edge.
REQ-005 SHALL have reset_n_i  in  1  reset, asynchronous and active-low.
REQ-006 SHALL have normal_mode_i  in  1  1 = normal (microcode) mode; 0 = uncached mode, no fetch.
REQ-007 SHALL have cfg_w_v_i, cfg_r_v_i  in  1 each  config RAM write and read strobes.
REQ-008 SHALL have cfg_addr_i  in  pc_width, and cfg_data_i  in  instr_width_p: config address and write data.
REQ-009 SHALL have cfg_r_v_o  out  1, and cfg_r_data_o  out  instr_width_p: config read response.
REQ-010 SHALL have boot_pc_i  in  ctx_p*pc_width  per-context start PC, context k at bits [k*pc_width +: pc_width].
REQ-011 SHALL have ctx_en_i  in  ctx_p  per-context fetch enable.
REQ-012 SHALL have inst_v_o  out  1, inst_o  out  instr_width_p, inst_ctx_o  out  ctx_width, and inst_pc_o  out  pc_width: instruction output with its context and PC.
REQ-013 SHALL have yumi_i  in  1  consumer accepts inst_o; legal only when inst_v_o=1.
REQ-014 SHALL have predicted_pc_i and resolution_pc_i  in  pc_width each, plus mispredict_i  in  1: next-PC information for inst_ctx_o, sampled with yumi_i.

Function
REQ-015 SHALL use one single-port synchronous RAM of els_p x instr_width_p with 1-cycle read latency; the address is registered inside the RAM.
REQ-016 SHALL implement states RESET, INIT, INIT_END and FETCH.
REQ-017 SHALL make these transitions: RESET->INIT unconditionally; INIT->INIT_END when normal_mode_i=1, else stay in INIT; INIT_END->FETCH; FETCH->INIT when normal_mode_i=0.
REQ-018 SHALL, in INIT_END, load each ctx_pc_r[k] from boot_pc_i[k], set the round-robin pointer to 0, and issue no fetch.
REQ-019 SHALL give config access priority over fetch in every state: RAM address = cfg_addr_i; write when cfg_w_v_i=1; cfg_w_v_i and cfg_r_v_i asserted together is a write only.
REQ-020 SHALL, for a config read accepted in cycle t, assert cfg_r_v_o for exactly one cycle at t+1 with cfg_r_data_o = RAM data.
REQ-021 SHALL make a FETCH-state cycle with config access issue no fetch: inst_v_o=0 in the next cycle, no ctx_pc_r change, and a held context stays held.
REQ-022 SHALL, in FETCH with no config access, select the fetch context as follows:
  - If inst_v_o=1 and yumi_i=0 (stall): refetch the same context at the same PC.
  - Otherwise: the first context with ctx_en_i=1 strictly after the last-served context, in round-robin order with wrap ctx_p-1 -> 0, including the last-served context itself.
REQ-023 SHALL, on yumi_i=1, write ctx_pc_r[inst_ctx_o] = mispredict_i ? resolution_pc_i : predicted_pc_i in the same edge.
REQ-024 SHALL, when the context selected in that cycle is the one just accepted, fetch the bypassed new PC rather than the stale register (back-to-back single-context fetch at full rate).
REQ-025 SHALL assert inst_v_o in cycle t+1 for every fetch issued in cycle t, with inst_ctx_o and inst_pc_o registered alongside.
REQ-026 SHALL keep a held (stalled) context selected even if its ctx_en_i drops, until yumi_i.
REQ-027 SHALL issue no fetch when no context is enabled and none is held; inst_v_o=0 next cycle.
REQ-028 SHALL force inst_v_o=0 in RESET, INIT and INIT_END, and ignore yumi_i whenever inst_v_o=0.
REQ-029 SHALL wrap PC arithmetic modulo els_p; yumi_i with inst_v_o=0 is illegal input and SHALL NOT corrupt state.

Reset
REQ-030 SHALL, while reset_n_i=0, immediately force state=RESET, inst_v_o=0, cfg_r_v_o=0, all ctx_pc_r=0, pointer=0, inst_ctx_o=0 and inst_pc_o=0.
REQ-031 SHALL discard any fetch or config read in flight when reset asserts mid-operation; RAM contents are not cleared.

Verification
REQ-032 SHALL be verified with: config write 0xAA at addr 5, then config read of addr 5 -> cfg_r_v_o=1 exactly one cycle later with cfg_r_data_o=0xAA.
REQ-033 SHALL be verified with: ctx_p=4, ctx_en_i=4'b1111, boot_pc_i={30,20,10,0}, yumi_i always 1 -> first four outputs ctx 0,1,2,3 at PCs 0,10,20,30.
REQ-034 SHALL be verified with: only context 2 enabled, yumi_i=1, predicted_pc_i=inst_pc_o+1 -> inst_v_o=1 every cycle, PCs consecutive (bypass).
REQ-035 SHALL be verified with: stall (yumi_i=0) for 3 cycles on ctx 1 at PC 12 -> ctx 1, PC 12 repeated; on yumi_i with mispredict_i=1 and resolution_pc_i=40, ctx 1's next fetch is PC 40.
REQ-036 SHALL be verified with: config write in the FETCH state -> inst_v_o=0 the next cycle, fetch resumes the following cycle with no PC skipped.
REQ-037 SHALL be verified with: normal_mode_i dropping in FETCH -> state INIT and inst_v_o=0; reset_n_i asserted mid-stall -> inst_v_o=0 immediately, no yumi effect.
